// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one multi-cycle divider among NUM_REQ issue lanes. Requests are
//   granted round-robin, operands are registered and the divider is started
//   with a one-cycle divReq pulse. The quotient or remainder comes back with
//   the requester's lane index and tag. The most recent completed operation is
//   remembered, so a repeat of the same operands (e.g. DIV then REM) is answered
//   without touching the divider. flush abandons the in-flight operation.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   reqValid/reqReady        per-lane request / one-hot grant (combinational)
//   reqDividend/reqDivisor   per-lane operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqIsSigned/reqIsRem     per-lane signed mode / return remainder
//   reqTag                   per-lane tag, lane i at [i*TAG_WIDTH +: TAG_WIDTH]
//   flush                    cancel in-flight op and pending response
//   divReq, divDividend, divDivisor, divIsSigned   divider start and operands
//   divFinished, divQuotient, divRemainder         divider status and results
//   respValid/respReady      response handshake
//   respOwner, respTag, respData                   response payload
module divider_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int TAG_WIDTH    = 6,
   parameter int ENABLE_REUSE = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               reqValid,
   output logic [NUM_REQ-1:0]               reqReady,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqDividend,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqDivisor,
   input  logic [NUM_REQ-1:0]               reqIsSigned,
   input  logic [NUM_REQ-1:0]               reqIsRem,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]     reqTag,
   input  logic                             flush,
   output logic                             divReq,
   output logic [DATA_WIDTH-1:0]            divDividend,
   output logic [DATA_WIDTH-1:0]            divDivisor,
   output logic                             divIsSigned,
   input  logic                             divFinished,
   input  logic [DATA_WIDTH-1:0]            divQuotient,
   input  logic [DATA_WIDTH-1:0]            divRemainder,
   output logic                             respValid,
   input  logic                             respReady,
   output logic [$clog2(NUM_REQ)-1:0]       respOwner,
   output logic [TAG_WIDTH-1:0]             respTag,
   output logic [DATA_WIDTH-1:0]            respData
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;

   // Latched operation
   logic [DATA_WIDTH-1:0]  dividend_q, dividend_d;
   logic [DATA_WIDTH-1:0]  divisor_q, divisor_d;
   logic                   signed_q, signed_d;
   logic                   is_rem_q, is_rem_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [IW-1:0]          owner_q, owner_d;

   // Response
   logic                   resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
   logic                   div_req_q, div_req_d;

   // Last completed divider operation
   logic                   last_valid_q, last_valid_d;
   logic [DATA_WIDTH-1:0]  last_dividend_q, last_dividend_d;
   logic [DATA_WIDTH-1:0]  last_divisor_q, last_divisor_d;
   logic                   last_signed_q, last_signed_d;
   logic [DATA_WIDTH-1:0]  last_quo_q, last_quo_d;
   logic [DATA_WIDTH-1:0]  last_rem_q, last_rem_d;

   // Round-robin winner
   logic [IW-1:0]          win_idx;
   logic                   win_found;
   int unsigned            scan_idx;

   // Winning lane's request fields
   logic [DATA_WIDTH-1:0]  sel_dividend, sel_divisor;
   logic                   sel_signed, sel_rem;
   logic [TAG_WIDTH-1:0]   sel_tag;
   logic                   accept, reuse_hit;

   // Search begins at rr_ptr_q and wraps; first valid lane wins.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = 32'(rr_ptr_q) + k;
         if (scan_idx >= 32'(NUM_REQ)) begin
            scan_idx = scan_idx - 32'(NUM_REQ);
         end
         if (!win_found && reqValid[IW'(scan_idx)]) begin
            win_found = 1'b1;
            win_idx   = IW'(scan_idx);
         end
      end
   end

   always_comb begin
      sel_dividend = reqDividend[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      sel_divisor  = reqDivisor[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      sel_signed   = reqIsSigned[win_idx];
      sel_rem      = reqIsRem[win_idx];
      sel_tag      = reqTag[32'(win_idx)*TAG_WIDTH +: TAG_WIDTH];
      reuse_hit    = (ENABLE_REUSE != 0) && last_valid_q &&
                     (sel_dividend == last_dividend_q) &&
                     (sel_divisor == last_divisor_q) &&
                     (sel_signed == last_signed_q);
   end

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      dividend_d      = dividend_q;
      divisor_d       = divisor_q;
      signed_d        = signed_q;
      is_rem_d        = is_rem_q;
      tag_d           = tag_q;
      owner_d         = owner_q;
      resp_data_d     = resp_data_q;
      last_valid_d    = last_valid_q;
      last_dividend_d = last_dividend_q;
      last_divisor_d  = last_divisor_q;
      last_signed_d   = last_signed_q;
      last_quo_d      = last_quo_q;
      last_rem_d      = last_rem_q;
      reqReady        = '0;
      accept          = 1'b0;

      // Grant only in IDLE, outside flush and reset.
      if (rst && !flush && (state_q == IDLE) && win_found) begin
         reqReady[win_idx] = 1'b1;
         accept            = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               dividend_d = sel_dividend;
               divisor_d  = sel_divisor;
               signed_d   = sel_signed;
               is_rem_d   = sel_rem;
               tag_d      = sel_tag;
               owner_d    = win_idx;
               rr_ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
               if (reuse_hit) begin
                  resp_data_d = sel_rem ? last_rem_q : last_quo_q;
                  state_d     = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // A result arriving together with flush is discarded entirely.
            if (divFinished && !flush) begin
               resp_data_d     = is_rem_q ? divRemainder : divQuotient;
               last_valid_d    = 1'b1;
               last_dividend_d = dividend_q;
               last_divisor_d  = divisor_q;
               last_signed_d   = signed_q;
               last_quo_d      = divQuotient;
               last_rem_d      = divRemainder;
               state_d         = RESP;
            end
         end
         RESP: begin
            if (respReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
      end

      resp_valid_d = (state_d == RESP);
      div_req_d    = (state_d == ISSUE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         rr_ptr_q        <= '0;
         dividend_q      <= '0;
         divisor_q       <= '0;
         signed_q        <= 1'b0;
         is_rem_q        <= 1'b0;
         tag_q           <= '0;
         owner_q         <= '0;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         div_req_q       <= 1'b0;
         last_valid_q    <= 1'b0;
         last_dividend_q <= '0;
         last_divisor_q  <= '0;
         last_signed_q   <= 1'b0;
         last_quo_q      <= '0;
         last_rem_q      <= '0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         dividend_q      <= dividend_d;
         divisor_q       <= divisor_d;
         signed_q        <= signed_d;
         is_rem_q        <= is_rem_d;
         tag_q           <= tag_d;
         owner_q         <= owner_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         div_req_q       <= div_req_d;
         last_valid_q    <= last_valid_d;
         last_dividend_q <= last_dividend_d;
         last_divisor_q  <= last_divisor_d;
         last_signed_q   <= last_signed_d;
         last_quo_q      <= last_quo_d;
         last_rem_q      <= last_rem_d;
      end
   end

   assign divReq      = div_req_q;
   assign divDividend = dividend_q;
   assign divDivisor  = divisor_q;
   assign divIsSigned = signed_q;
   assign respValid   = resp_valid_q;
   assign respOwner   = owner_q;
   assign respTag     = tag_q;
   assign respData    = resp_data_q;

endmodule
